icetap_capture_core: RTL and testbench

Sample-domain capture engine of the icetap logic analyzer: evaluates per-signal store and trigger conditions on `signals_in`, writes qualified samples into a circular record RAM, and reports start/trigger/stop addresses. Sits directly downstream of the JTAG register block. That block delivers mask registers and clk-domain command pulses, and reads status and RAM data back through this core.

---
 rtl/icetap_pkg.sv | 42 ++++
 rtl/icetap_capture_core_if.sv | 34 +++
 rtl/icetap_ram.sv | 46 ++++
 rtl/icetap_capture_core.sv | 177 +++++++++++++++++
 tb/tb_icetap_capture_core.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icetap_pkg.sv
// rtl/icetap_pkg.sv - shared state/condition encodings for the icetap capture engine
//
// Purpose : capture FSM state encoding, per-signal condition codes and the
//           helper that evaluates one condition code against current and
//           previous-cycle signal values.
// Ports   : none (package).
package icetap_pkg;

  localparam int COND_W = 3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRE_TRIGGER  = 2'd1,
    POST_TRIGGER = 2'd2
  } state_e;

  // Codes 6 and 7 are intentionally absent: they behave like COND_DC.
  typedef enum logic [COND_W-1:0] {
    COND_DC   = 3'd0,
    COND_HIGH = 3'd1,
    COND_LOW  = 3'd2,
    COND_RISE = 3'd3,
    COND_FALL = 3'd4,
    COND_EDGE = 3'd5
  } cond_e;

  function automatic logic cond_match(input logic [COND_W-1:0] code,
                                      input logic               s,
                                      input logic               p);
    logic hit;
    case (code)
      COND_HIGH: hit = s;
      COND_LOW:  hit = ~s;
      COND_RISE: hit = ~p & s;
      COND_FALL: hit = p & ~s;
      COND_EDGE: hit = p ^ s;
      default:   hit = 1'b1;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/icetap_capture_core_if.sv
// rtl/icetap_capture_core_if.sv - register-block side bundle of the capture core
//
// Purpose : groups the masks, command pulses, readout port and status words
//           exchanged between the JTAG register block and the capture core.
// Modports: master = register block (drives masks/commands/rd_addr),
//           slave  = capture core (drives rd_data and status).
interface icetap_capture_core_if #(
  parameter int NR_SIGNALS = 16,
  parameter int ADDR_W     = 9
);
  logic [3*NR_SIGNALS-1:0] store_mask;
  logic [3*NR_SIGNALS-1:0] trigger_mask;
  logic                    cmd_start;
  logic                    cmd_abort;
  logic [ADDR_W-1:0]       rd_addr;
  logic [NR_SIGNALS-1:0]   rd_data;
  logic                    status_idle;
  logic [1:0]              status_state;
  logic [ADDR_W-1:0]       status_start_addr;
  logic [ADDR_W-1:0]       status_trigger_addr;
  logic [ADDR_W-1:0]       status_stop_addr;

  modport master (
    output store_mask, trigger_mask, cmd_start, cmd_abort, rd_addr,
    input  rd_data, status_idle, status_state,
           status_start_addr, status_trigger_addr, status_stop_addr
  );

  modport slave (
    input  store_mask, trigger_mask, cmd_start, cmd_abort, rd_addr,
    output rd_data, status_idle, status_state,
           status_start_addr, status_trigger_addr, status_stop_addr
  );
endinterface

// File: rtl/icetap_ram.sv
// rtl/icetap_ram.sv - sample record RAM, one write port and one registered read port
//
// Purpose : WIDTH x DEPTH simple dual-port memory shaped for iCE40 EBR
//           inference. Read of an address written in the same cycle returns
//           the old word. Contents are never cleared; only the read register
//           is reset.
// Ports   : clk, reset_ (async, active-high), wr_en/wr_addr/wr_data,
//           rd_addr -> rd_data (1-cycle latency).
module icetap_ram #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/icetap_capture_core.sv
// rtl/icetap_capture_core.sv - icetap sample-domain capture engine
//
// Purpose : evaluates per-signal store/trigger conditions on signals_in,
//           writes qualified samples into a circular record RAM and reports
//           the start/trigger/stop addresses of the last capture.
// Ports   : clk, reset_ (async, active-high), signals_in (probed signals),
//           bus (slave side of icetap_capture_core_if: masks, start/abort
//           pulses, RAM readout and status).
module icetap_capture_core
  import icetap_pkg::*;
#(
  parameter  int NR_SIGNALS   = 16,
  parameter  int RECORD_DEPTH = 512,
  parameter  int POST_SAMPLES = RECORD_DEPTH / 2,
  localparam int ADDR_W       = $clog2(RECORD_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [NR_SIGNALS-1:0] signals_in,
  icetap_capture_core_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(RECORD_DEPTH - 1);
  localparam logic [ADDR_W-1:0] POST_TARGET = ADDR_W'(POST_SAMPLES);
  localparam logic              NO_POST     = (POST_SAMPLES == 0);

  state_e                state_q, state_d;
  logic                  idle_q, idle_d;
  logic [NR_SIGNALS-1:0] p_q, p_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic                  wrapped_q, wrapped_d;
  logic [ADDR_W-1:0]     post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]     trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]     stop_addr_q, stop_addr_d;
  logic [ADDR_W-1:0]     start_addr_q, start_addr_d;

  logic [NR_SIGNALS-1:0] store_hit, trig_hit;
  logic                  store_ok, trig_ok;
  logic                  abort_ev, trig_ev, wr_en, post_done, capture_end;
  logic [ADDR_W-1:0]     last_addr;

  // Per-signal condition evaluation; the overall condition is the AND.
  for (genvar i = 0; i < NR_SIGNALS; i++) begin : g_cond
    assign store_hit[i] = cond_match(bus.store_mask[COND_W*i +: COND_W],
                                     signals_in[i], p_q[i]);
    assign trig_hit[i]  = cond_match(bus.trigger_mask[COND_W*i +: COND_W],
                                     signals_in[i], p_q[i]);
  end

  assign store_ok = &store_hit;
  assign trig_ok  = &trig_hit;

  // Abort pre-empts everything in the same cycle, including the write.
  assign abort_ev    = bus.cmd_abort && (state_q != IDLE);
  assign trig_ev     = (state_q == PRE_TRIGGER) && !bus.cmd_abort && trig_ok;
  assign wr_en       = (state_q != IDLE) && !bus.cmd_abort && (store_ok || trig_ev);
  assign post_done   = (state_q == POST_TRIGGER) && wr_en &&
                       ((post_cnt_q + ADDR_ONE) == POST_TARGET);
  assign capture_end = abort_ev || post_done || (trig_ev && NO_POST);

  // State register (plus all datapath flops).
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_q      <= IDLE;
      idle_q       <= 1'b1;
      p_q          <= '0;
      wr_addr_q    <= '0;
      wrapped_q    <= 1'b0;
      post_cnt_q   <= '0;
      trig_addr_q  <= '0;
      stop_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      p_q          <= p_d;
      wr_addr_q    <= wr_addr_d;
      wrapped_q    <= wrapped_d;
      post_cnt_q   <= post_cnt_d;
      trig_addr_q  <= trig_addr_d;
      stop_addr_q  <= stop_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_start && !bus.cmd_abort) begin
          state_d = PRE_TRIGGER;
        end
      end
      PRE_TRIGGER: begin
        if (capture_end) begin
          state_d = IDLE;
        end else if (trig_ev) begin
          state_d = POST_TRIGGER;
        end
      end
      POST_TRIGGER: begin
        if (capture_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    idle_d       = (state_d == IDLE);
    p_d          = signals_in;
    wr_addr_d    = wr_addr_q;
    wrapped_d    = wrapped_q;
    post_cnt_d   = post_cnt_q;
    trig_addr_d  = trig_addr_q;
    stop_addr_d  = stop_addr_q;
    start_addr_d = start_addr_q;
    last_addr    = '0;

    if ((state_q == IDLE) && (state_d == PRE_TRIGGER)) begin
      wr_addr_d  = '0;
      wrapped_d  = 1'b0;
      post_cnt_d = '0;
    end

    if (wr_en) begin
      wr_addr_d = wr_addr_q + ADDR_ONE;
      if (wr_addr_q == ADDR_LAST) begin
        wrapped_d = 1'b1;
      end
      if (state_q == POST_TRIGGER) begin
        post_cnt_d = post_cnt_q + ADDR_ONE;
      end
    end

    if (trig_ev) begin
      trig_addr_d = wr_addr_q;
    end

    // Nothing written yet is the only case where wr_addr==0 without a wrap.
    if (capture_end) begin
      if (wr_en) begin
        last_addr = wr_addr_q;
      end else if ((wr_addr_q == '0) && !wrapped_q) begin
        last_addr = '0;
      end else begin
        last_addr = wr_addr_q - ADDR_ONE;
      end
      stop_addr_d  = last_addr;
      start_addr_d = wrapped_d ? (last_addr + ADDR_ONE) : '0;
    end
  end

  icetap_ram #(
    .WIDTH (NR_SIGNALS),
    .DEPTH (RECORD_DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_  (reset_),
    .wr_en   (wr_en),
    .wr_addr (wr_addr_q),
    .wr_data (signals_in),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.status_idle         = idle_q;
  assign bus.status_state        = state_q;
  assign bus.status_start_addr   = start_addr_q;
  assign bus.status_trigger_addr = trig_addr_q;
  assign bus.status_stop_addr    = stop_addr_q;

endmodule

// File: tb/tb_icetap_capture_core.sv
// tb/tb_icetap_capture_core.sv - testbench for icetap_capture_core
module tb_icetap_capture_core;

  localparam int NS  = 16;
  localparam int DA  = 512;
  localparam int PA  = 256;
  localparam int AWA = 9;
  localparam int DB  = 8;
  localparam int PB  = 0;
  localparam int AWB = 3;

  logic          clk = 1'b0;
  logic          reset_ = 1'b1;
  logic [NS-1:0] signals_in = '0;
  bit            cnt_mode = 1'b0;
  bit            model_on = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  icetap_capture_core_if #(.NR_SIGNALS(NS), .ADDR_W(AWA)) a_if ();
  icetap_capture_core_if #(.NR_SIGNALS(NS), .ADDR_W(AWB)) b_if ();

  icetap_capture_core #(.NR_SIGNALS(NS), .RECORD_DEPTH(DA), .POST_SAMPLES(PA)) u_dut_a (
    .clk(clk), .reset_(reset_), .signals_in(signals_in), .bus(a_if.slave));

  icetap_capture_core #(.NR_SIGNALS(NS), .RECORD_DEPTH(DB), .POST_SAMPLES(PB)) u_dut_b (
    .clk(clk), .reset_(reset_), .signals_in(signals_in), .bus(b_if.slave));

  // Reference model: a capture is a count of writes; addresses are that count mod depth.
  int            m_state [2];
  int            m_nwr   [2];
  int            m_post  [2];
  int            m_trig  [2];
  int            m_stop  [2];
  int            m_start [2];
  logic [NS-1:0] m_mem   [2][DA];
  bit            m_val   [2][DA];
  logic [NS-1:0] m_rd    [2];
  bit            m_rdv   [2];
  logic [NS-1:0] m_p;

  typedef struct {
    string       name;
    logic [47:0] sm;
    logic [47:0] tm;
    logic [15:0] cnt0;
    int          e_trig;
    int          e_stop;
    int          e_start;
    logic [15:0] w_trig;
    logic [15:0] w_stop;
    logic [15:0] w_start;
    bit          odd_only;
  } vec_t;

  vec_t tbl [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic bit cond_true(input logic [47:0] mask, input logic [15:0] s, input logic [15:0] p);
    bit ok = 1'b1;
    for (int i = 0; i < NS; i++) begin
      logic [2:0] c;
      c = mask[3*i +: 3];
      if (c == 3'd1 && s[i] != 1'b1) ok = 1'b0;
      if (c == 3'd2 && s[i] != 1'b0) ok = 1'b0;
      if (c == 3'd3 && !(p[i] == 1'b0 && s[i] == 1'b1)) ok = 1'b0;
      if (c == 3'd4 && !(p[i] == 1'b1 && s[i] == 1'b0)) ok = 1'b0;
      if (c == 3'd5 && p[i] == s[i]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [47:0] exact_mask(input logic [15:0] v);
    logic [47:0] m = '0;
    for (int i = 0; i < NS; i++) m[3*i +: 3] = v[i] ? 3'd1 : 3'd2;
    return m;
  endfunction

  task automatic model_write(input int k, input int d);
    int wa;
    wa = m_nwr[k] % d;
    m_mem[k][wa] = signals_in;
    m_val[k][wa] = 1'b1;
    m_nwr[k]++;
  endtask

  task automatic model_finish(input int k, input int d);
    m_stop[k]  = (m_nwr[k] == 0) ? 0 : (m_nwr[k] - 1) % d;
    m_start[k] = (m_nwr[k] >= d) ? (m_stop[k] + 1) % d : 0;
    m_state[k] = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_nwr[k] = 0; m_post[k] = 0;
      m_trig[k] = 0; m_stop[k] = 0; m_start[k] = 0;
      m_rd[k] = '0; m_rdv[k] = 1'b1;
    end
    m_p = '0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [47:0] sm, tm;
      logic        st, ab;
      int          ra, d, ps;
      bit          s_ok, t_ok;
      if (k == 0) begin
        sm = a_if.store_mask; tm = a_if.trigger_mask; st = a_if.cmd_start; ab = a_if.cmd_abort;
        ra = int'(a_if.rd_addr); d = DA; ps = PA;
      end else begin
        sm = b_if.store_mask; tm = b_if.trigger_mask; st = b_if.cmd_start; ab = b_if.cmd_abort;
        ra = int'(b_if.rd_addr); d = DB; ps = PB;
      end
      s_ok = cond_true(sm, signals_in, m_p);
      t_ok = cond_true(tm, signals_in, m_p);
      m_rdv[k] = m_val[k][ra];
      m_rd[k]  = m_mem[k][ra];
      case (m_state[k])
        0: if (st && !ab) begin m_state[k] = 1; m_nwr[k] = 0; m_post[k] = 0; end
        1: begin
          if (ab) model_finish(k, d);
          else if (t_ok) begin
            m_trig[k] = m_nwr[k] % d;
            model_write(k, d);
            if (ps == 0) model_finish(k, d);
            else m_state[k] = 2;
          end else if (s_ok) model_write(k, d);
        end
        default: begin
          if (ab) model_finish(k, d);
          else if (s_ok) begin
            model_write(k, d);
            m_post[k]++;
            if (m_post[k] == ps) model_finish(k, d);
          end
        end
      endcase
    end
    m_p = signals_in;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (model_on) model_step();
    #1;
    a_if.cmd_start = 1'b0; a_if.cmd_abort = 1'b0;
    b_if.cmd_start = 1'b0; b_if.cmd_abort = 1'b0;
    if (cnt_mode) signals_in = signals_in + 16'd1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (a_if.status_idle !== 1'b1 && n < budget) begin cyc(); n++; end
    chk({name, "_reached_idle"}, 64'(a_if.status_idle), 64'(1));
  endtask

  task automatic rd_a(input int addr, output logic [15:0] d);
    a_if.rd_addr = AWA'(addr);
    cyc();
    d = a_if.rd_data;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_state"}, 64'(a_if.status_state), 64'(0));
    chk({name, "_idle"},  64'(a_if.status_idle), 64'(1));
    chk({name, "_addrs"}, 64'({a_if.status_start_addr, a_if.status_trigger_addr, a_if.status_stop_addr}), 64'(0));
    chk({name, "_rd_data"}, 64'(a_if.rd_data), 64'(0));
  endtask

  function automatic logic [47:0] rand_store_mask();
    logic [47:0] m = '0;
    for (int i = 0; i < NS; i++)
      if ($urandom_range(0, 7) == 0) m[3*i +: 3] = 3'($urandom_range(0, 7));
    return m;
  endfunction

  function automatic logic [47:0] rand_trig_mask();
    logic [47:0] m = '0;
    int n;
    n = ($urandom_range(0, 3) == 0) ? 4 : 1;
    for (int j = 0; j < n; j++) begin
      int idx;
      idx = int'($urandom_range(0, NS - 1));
      m[3*idx +: 3] = 3'($urandom_range(1, 7));
    end
    return m;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int bad, post_words;

    a_if.store_mask = '0; a_if.trigger_mask = '0; a_if.cmd_start = 1'b0; a_if.cmd_abort = 1'b0; a_if.rd_addr = '0;
    b_if.store_mask = '0; b_if.trigger_mask = '0; b_if.cmd_start = 1'b0; b_if.cmd_abort = 1'b0; b_if.rd_addr = '0;

    tbl[0] = '{"cnt_store_all", 48'h0, exact_mask(16'h1c00), 16'h0010, 495, 239, 240,
               16'h1c00, 16'h1d00, 16'h1b01, 1'b0};
    tbl[1] = '{"cnt_store_odd", 48'h1, exact_mask(16'h1c00), 16'h0010, 504, 248, 249,
               16'h1c00, 16'h1dff, 16'h1a03, 1'b1};
    tbl[2] = '{"rise_bit3_nowrap", 48'h0, 48'h600, 16'h0102, 5, 261, 0,
               16'h0108, 16'h0208, 16'h0103, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_ = 1'b0;
    cyc();

    // Table-driven full captures on a counter source.
    for (int v = 0; v < 3; v++) begin
      a_if.store_mask = tbl[v].sm;
      a_if.trigger_mask = tbl[v].tm;
      cnt_mode = 1'b1;
      signals_in = tbl[v].cnt0;
      a_if.cmd_start = 1'b1;
      cyc();
      chk({tbl[v].name, "_state_pre"}, 64'(a_if.status_state), 64'(1));
      chk({tbl[v].name, "_idle_low"}, 64'(a_if.status_idle), 64'(0));
      wait_idle(20000, tbl[v].name);
      chk({tbl[v].name, "_trig_addr"}, 64'(a_if.status_trigger_addr), 64'(tbl[v].e_trig));
      chk({tbl[v].name, "_stop_addr"}, 64'(a_if.status_stop_addr), 64'(tbl[v].e_stop));
      chk({tbl[v].name, "_start_addr"}, 64'(a_if.status_start_addr), 64'(tbl[v].e_start));
      rd_a(tbl[v].e_trig, w);  chk({tbl[v].name, "_ram_trig"}, 64'(w), 64'(tbl[v].w_trig));
      rd_a(tbl[v].e_stop, w);  chk({tbl[v].name, "_ram_stop"}, 64'(w), 64'(tbl[v].w_stop));
      rd_a(tbl[v].e_start, w); chk({tbl[v].name, "_ram_start"}, 64'(w), 64'(tbl[v].w_start));
      if (tbl[v].odd_only) begin
        bad = 0; post_words = 0;
        for (int a = 0; a < DA; a++) begin
          rd_a(a, w);
          if (w[0] == 1'b0 && w != 16'h1c00) bad++;
          if (w[0] == 1'b1 && w > 16'h1c00 && w <= 16'h1dff) post_words++;
        end
        chk({tbl[v].name, "_even_words"}, 64'(bad), 64'(0));
        chk({tbl[v].name, "_post_words"}, 64'(post_words), 64'(256));
      end
    end

    // Exact trigger timing, then a second start during POST_TRIGGER.
    a_if.store_mask = 48'h0; a_if.trigger_mask = 48'h600;
    signals_in = 16'h0102; a_if.cmd_start = 1'b1;
    cyc();
    repeat (5) cyc();
    chk("trig_timing_still_pre", 64'(a_if.status_state), 64'(1));
    cyc();
    chk("trig_timing_post", 64'(a_if.status_state), 64'(2));
    chk("trig_timing_addr", 64'(a_if.status_trigger_addr), 64'(5));
    repeat (3) cyc();
    a_if.cmd_start = 1'b1;
    cyc();
    chk("restart_in_post_ignored", 64'(a_if.status_state), 64'(2));
    wait_idle(2000, "restart_in_post");
    chk("restart_in_post_stop", 64'(a_if.status_stop_addr), 64'(261));
    chk("restart_in_post_start", 64'(a_if.status_start_addr), 64'(0));

    // Abort in PRE_TRIGGER after 20 stores; trigger can never fire here.
    a_if.trigger_mask = exact_mask(16'hffff);
    signals_in = 16'h0200; a_if.cmd_start = 1'b1;
    cyc();
    repeat (20) cyc();
    chk("abort_before_still_pre", 64'(a_if.status_state), 64'(1));
    a_if.cmd_abort = 1'b1;
    cyc();
    chk("abort_idle", 64'(a_if.status_idle), 64'(1));
    chk("abort_stop", 64'(a_if.status_stop_addr), 64'(19));
    chk("abort_start", 64'(a_if.status_start_addr), 64'(0));
    chk("abort_trig_kept", 64'(a_if.status_trigger_addr), 64'(5));

    // Start and abort together in IDLE.
    a_if.cmd_start = 1'b1; a_if.cmd_abort = 1'b1;
    cyc();
    chk("start_abort_idle_0", 64'(a_if.status_state), 64'(0));
    cyc();
    chk("start_abort_idle_1", 64'(a_if.status_state), 64'(0));

    // Reset asserted in POST_TRIGGER: outputs clear at once, RAM survives.
    a_if.trigger_mask = 48'h600;
    signals_in = 16'h0102; a_if.cmd_start = 1'b1;
    cyc();
    repeat (6) cyc();
    repeat (10) cyc();
    chk("reset_mid_post_was_post", 64'(a_if.status_state), 64'(2));
    reset_ = 1'b1;
    #1;
    chk_reset_outputs("reset_mid_post");
    @(posedge clk);
    #1;
    reset_ = 1'b0;
    rd_a(0, w);  chk("reset_ram_keep_0", 64'(w), 64'(16'h0103));
    rd_a(5, w);  chk("reset_ram_keep_5", 64'(w), 64'(16'h0108));
    rd_a(10, w); chk("reset_ram_keep_10", 64'(w), 64'(16'h010d));

    // Randomized run against the reference model on both instances.
    cnt_mode = 1'b0;
    for (int k = 0; k < 2; k++) for (int a = 0; a < DA; a++) m_val[k][a] = 1'b0;
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    reset_ = 1'b0;
    model_reset();
    model_on = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      logic st, ab;
      if (c == 3000) begin
        reset_ = 1'b1;
        #1;
        chk_reset_outputs("rnd_reset");
        @(posedge clk);
        #1;
        reset_ = 1'b0;
        model_reset();
      end
      if (m_state[0] == 0 && m_state[1] == 0 && $urandom_range(0, 3) == 0) begin
        a_if.store_mask = rand_store_mask();
        a_if.trigger_mask = rand_trig_mask();
        b_if.store_mask = a_if.store_mask;
        b_if.trigger_mask = a_if.trigger_mask;
      end
      st = ($urandom_range(0, 15) == 0);
      ab = ($urandom_range(0, 199) == 0);
      a_if.cmd_start = st; a_if.cmd_abort = ab;
      b_if.cmd_start = st; b_if.cmd_abort = ab;
      signals_in = 16'($urandom);
      a_if.rd_addr = AWA'($urandom_range(0, DA - 1));
      b_if.rd_addr = AWB'($urandom_range(0, DB - 1));
      cyc();
      chk("rnd_a_status",
          64'({a_if.status_state, a_if.status_idle, a_if.status_start_addr,
               a_if.status_trigger_addr, a_if.status_stop_addr}),
          64'({2'(m_state[0]), (m_state[0] == 0), AWA'(m_start[0]), AWA'(m_trig[0]), AWA'(m_stop[0])}));
      chk("rnd_b_status",
          64'({b_if.status_state, b_if.status_idle, b_if.status_start_addr,
               b_if.status_trigger_addr, b_if.status_stop_addr}),
          64'({2'(m_state[1]), (m_state[1] == 0), AWB'(m_start[1]), AWB'(m_trig[1]), AWB'(m_stop[1])}));
      if (m_rdv[0]) chk("rnd_a_rd_data", 64'(a_if.rd_data), 64'(m_rd[0]));
      if (m_rdv[1]) chk("rnd_b_rd_data", 64'(b_if.rd_data), 64'(m_rd[1]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
